// File: rtl/encoder_pkg.sv
// Shared types and constants for the encoder snapshot path.
package encoder_pkg;

  localparam int ENC_POS_W  = 32;
  localparam int ENC_TS_W   = 32;
  localparam int ENC_DROP_W = 16;

  // Capture source bits; both set means a periodic tick and a trigger coincided.
  localparam logic [1:0] SRC_PERIODIC = 2'b01;
  localparam logic [1:0] SRC_TRIGGER  = 2'b10;

  typedef struct packed {
    logic signed [ENC_POS_W-1:0] position;
    logic signed [ENC_POS_W-1:0] velocity;
    logic                        direction;
    logic [ENC_TS_W-1:0]         timestamp;
    logic [1:0]                  src;
  } enc_sample_t;

  localparam int ENC_SAMPLE_W = $bits(enc_sample_t);

endpackage

// File: rtl/enc_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head word is presented
// whenever the FIFO is non-empty and is forced to zero while empty, so the
// outputs depend on registers only (never on pop).
module enc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_pop_s;
  logic             do_push_s;

  assign full_s    = (count_r == FULL_CNT);
  assign empty_s   = (count_r == {(AW+1){1'b0}});
  // A pop can only happen on a non-empty FIFO; a push into a full FIFO is
  // allowed only when the head leaves in the same cycle.
  assign do_pop_s  = pop && !empty_s;
  assign do_push_s = push && (!full_s || do_pop_s);

  // Storage write; flush and reset suppress the write in their cycle.
  always_ff @(posedge clk) begin
    if (reset_n && !flush && do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_valid = !empty_s;
  assign head_data  = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign fill       = count_r;
  assign full       = full_s;

endmodule

// File: rtl/encoder_sample_fifo.sv
// Snapshot capture of encoder state into a FIFO drained by a slow reader.
// Holds the free-running timestamp, the periodic interval counter, capture
// arbitration and drop accounting. The recorded timestamp is the count value
// produced by the capture edge, i.e. the number of edges since reset release.
module encoder_sample_fifo
  import encoder_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 1_000_000,
  parameter int DEPTH         = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        trigger,
  input  logic                        flush,
  input  logic signed [ENC_POS_W-1:0] position,
  input  logic signed [ENC_POS_W-1:0] velocity,
  input  logic                        direction,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [ENC_POS_W-1:0] m_position,
  output logic signed [ENC_POS_W-1:0] m_velocity,
  output logic                        m_direction,
  output logic [ENC_TS_W-1:0]         m_timestamp,
  output logic [1:0]                  m_src,
  output logic [$clog2(DEPTH):0]      fill,
  output logic                        overflow,
  output logic [ENC_DROP_W-1:0]       drop_count
);

  localparam int IW = $clog2(SAMPLE_CYCLES);
  localparam logic [IW-1:0]         INT_LAST = IW'(SAMPLE_CYCLES - 1);
  localparam logic [IW-1:0]         INT_ONE  = IW'(1);
  localparam logic [ENC_DROP_W-1:0] DROP_MAX = {ENC_DROP_W{1'b1}};

  logic [ENC_TS_W-1:0]   ts_r;
  logic [ENC_TS_W-1:0]   ts_next_s;
  logic [IW-1:0]         int_r;
  logic                  periodic_s;
  logic                  capture_s;
  logic                  full_s;
  logic                  drop_s;
  logic                  overflow_r;
  logic [ENC_DROP_W-1:0] drop_r;
  enc_sample_t           sample_s;
  enc_sample_t           head_s;
  logic [ENC_SAMPLE_W-1:0] head_bits_s;

  assign ts_next_s  = ts_r + 32'd1;
  assign periodic_s = enable && (int_r == INT_LAST);
  assign capture_s  = periodic_s || trigger;
  // A full FIFO always has a valid head, so m_ready alone decides whether
  // the head leaves and frees a slot for the capture.
  assign drop_s     = capture_s && full_s && !m_ready;

  // Free-running timestamp; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts_r <= {ENC_TS_W{1'b0}};
    end else begin
      ts_r <= ts_next_s;
    end
  end

  // Periodic interval counter; holds while disabled, wraps after the last count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      int_r <= {IW{1'b0}};
    end else if (flush) begin
      int_r <= {IW{1'b0}};
    end else if (enable) begin
      if (int_r == INT_LAST) begin
        int_r <= {IW{1'b0}};
      end else begin
        int_r <= int_r + INT_ONE;
      end
    end else begin
      int_r <= int_r;
    end
  end

  // Assemble the snapshot written on a capture.
  always_comb begin
    sample_s           = '{default: '0};
    sample_s.position  = position;
    sample_s.velocity  = velocity;
    sample_s.direction = direction;
    sample_s.timestamp = ts_next_s;
    sample_s.src       = (periodic_s ? SRC_PERIODIC : 2'b00) |
                         (trigger    ? SRC_TRIGGER  : 2'b00);
  end

  // Sticky overflow and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
      drop_r     <= {ENC_DROP_W{1'b0}};
    end else if (flush) begin
      overflow_r <= 1'b0;
      drop_r     <= {ENC_DROP_W{1'b0}};
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_r != DROP_MAX) begin
        drop_r <= drop_r + 16'd1;
      end
    end else begin
      overflow_r <= overflow_r;
      drop_r     <= drop_r;
    end
  end

  enc_sync_fifo #(
    .WIDTH (ENC_SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .push       (capture_s),
    .push_data  (sample_s),
    .pop        (m_ready),
    .head_data  (head_bits_s),
    .head_valid (m_valid),
    .fill       (fill),
    .full       (full_s)
  );

  assign head_s      = head_bits_s;
  assign m_position  = head_s.position;
  assign m_velocity  = head_s.velocity;
  assign m_direction = head_s.direction;
  assign m_timestamp = head_s.timestamp;
  assign m_src       = head_s.src;
  assign overflow    = overflow_r;
  assign drop_count  = drop_r;

endmodule

// File: tb/tb_encoder_sample_fifo.sv
// Self-checking bench: a cycle-level queue model acts as scoreboard, a
// vector table covers the full/overflow/flush corners, and short sequences
// cover periodic timing, coincident sources, reset and enable gating.
module tb_encoder_sample_fifo;
  import encoder_pkg::*;

  localparam int S = 8;
  localparam int D = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic               trigger = 1'b0;
  logic               flush = 1'b0;
  logic signed [31:0] position = 32'sd0;
  logic signed [31:0] velocity = 32'sd0;
  logic               direction = 1'b0;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic signed [31:0] m_position;
  logic signed [31:0] m_velocity;
  logic               m_direction;
  logic [31:0]        m_timestamp;
  logic [1:0]         m_src;
  logic [2:0]         fill;
  logic               overflow;
  logic [15:0]        drop_count;

  always #5 clk = ~clk;

  encoder_sample_fifo #(.SAMPLE_CYCLES(S), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .trigger(trigger),
    .flush(flush), .position(position), .velocity(velocity),
    .direction(direction), .m_valid(m_valid), .m_ready(m_ready),
    .m_position(m_position), .m_velocity(m_velocity),
    .m_direction(m_direction), .m_timestamp(m_timestamp), .m_src(m_src),
    .fill(fill), .overflow(overflow), .drop_count(drop_count)
  );

  typedef struct {
    logic [31:0]        ts;
    logic signed [31:0] pos;
    logic [1:0]         src;
  } pop_t;

  typedef struct {
    logic        fl;
    logic        tr;
    logic        rd;
    logic [2:0]  fill;
    logic        ovf;
    logic [15:0] drop;
  } vec_t;

  int          n_vec = 0;
  int          n_miss = 0;
  enc_sample_t model_q[$];
  pop_t        popped[$];
  int unsigned ts_model = 0;
  int          model_int = 0;
  logic        model_ovf = 1'b0;
  logic [15:0] model_drop = 16'd0;
  vec_t        vt[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic step(input logic rst, input logic fl, input logic en,
                      input logic tr, input logic rd);
    logic        per;
    logic        did_pop;
    int          pre_size;
    enc_sample_t e;
    pop_t        h;
    reset_n   = !rst;
    flush     = fl;
    enable    = en;
    trigger   = tr;
    m_ready   = rd;
    position  = ts_model;
    velocity  = -3 * int'(ts_model);
    direction = ts_model[0];
    h.ts  = m_timestamp;
    h.pos = m_position;
    h.src = m_src;
    per      = en && (model_int == S - 1);
    pre_size = model_q.size();
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
      model_ovf  = 1'b0;
      model_drop = 16'd0;
      model_int  = 0;
      ts_model   = 0;
    end else begin
      if (fl) begin
        model_q.delete();
        model_ovf  = 1'b0;
        model_drop = 16'd0;
        model_int  = 0;
      end else begin
        did_pop = rd && (pre_size > 0);
        if (did_pop) begin
          void'(model_q.pop_front());
          popped.push_back(h);
        end
        if (per || tr) begin
          if (pre_size == D && !did_pop) begin
            model_ovf = 1'b1;
            if (model_drop != 16'hFFFF) model_drop++;
          end else begin
            e.position  = position;
            e.velocity  = velocity;
            e.direction = direction;
            e.timestamp = ts_model + 1;
            e.src       = {tr, per};
            model_q.push_back(e);
          end
        end
        if (en) model_int = (model_int == S - 1) ? 0 : model_int + 1;
      end
      ts_model++;
    end
    chk("m_valid", m_valid, model_q.size() != 0);
    chk("fill", fill, model_q.size());
    chk("overflow", overflow, model_ovf);
    chk("drop_count", drop_count, model_drop);
    if (model_q.size() > 0) begin
      chk("head_position", m_position, model_q[0].position);
      chk("head_velocity", m_velocity, model_q[0].velocity);
      chk("head_direction", m_direction, model_q[0].direction);
      chk("head_timestamp", m_timestamp, model_q[0].timestamp);
      chk("head_src", m_src, model_q[0].src);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_fill"}, fill, 3'd0);
    chk({tag, "_overflow"}, overflow, 1'b0);
    chk({tag, "_drop"}, drop_count, 16'd0);
    chk({tag, "_m_position"}, m_position, 32'd0);
    chk({tag, "_m_velocity"}, m_velocity, 32'd0);
    chk({tag, "_m_direction"}, m_direction, 1'b0);
    chk({tag, "_m_timestamp"}, m_timestamp, 32'd0);
    chk({tag, "_m_src"}, m_src, 2'd0);
  endtask

  initial begin
    logic [31:0] first_ts;
    logic [31:0] last_ts;
    logic        hit;
    // fl, tr, rd | fill, ovf, drop   (enable held low throughout)
    vt[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 16'd0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 16'd0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 16'd0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 16'd0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 16'd1};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 16'd2};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 16'd2};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 16'd2};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 16'd2};
    vt[10] = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 16'd2};
    vt[11] = '{1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 16'd2};
    vt[12] = '{1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 16'd2};
    vt[13] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 16'd0};
    vt[14] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0};
    first_ts = 32'd0;
    last_ts  = 32'd0;

    // Reset state
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_all_zero("reset");

    // Periodic capture: timestamps 8, 16, 24 with positions 7, 15, 23
    popped.delete();
    for (int i = 0; i < 26; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("periodic_count", popped.size(), 3);
    for (int i = 0; i < 3 && i < popped.size(); i++) begin
      chk($sformatf("periodic%0d_ts", i), popped[i].ts, 8 * (i + 1));
      chk($sformatf("periodic%0d_pos", i), popped[i].pos, 8 * (i + 1) - 1);
      chk($sformatf("periodic%0d_src", i), popped[i].src, 2'b01);
    end

    // Trigger coinciding with the periodic tick: one entry, src 11
    hit = 1'b0;
    for (int i = 0; i < 16 && !hit; i++) begin
      hit = (model_int == S - 1);
      step(1'b0, 1'b0, 1'b1, hit, 1'b0);
    end
    chk("coincide_fill", fill, 3'd1);
    chk("coincide_src", m_src, 2'b11);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Vector table: fill to full, overflow, push+pop on full, drain, flush
    for (int i = 0; i < 15; i++) begin
      step(1'b0, vt[i].fl, 1'b0, vt[i].tr, vt[i].rd);
      chk($sformatf("vec%0d_fill", i), fill, vt[i].fill);
      chk($sformatf("vec%0d_overflow", i), overflow, vt[i].ovf);
      chk($sformatf("vec%0d_drop", i), drop_count, vt[i].drop);
      if (i == 1) first_ts = ts_model;
      if (i == 6) chk("head_is_first_trigger", m_timestamp, first_ts);
      if (i == 7) last_ts = ts_model;
      if (i == 10) chk("last_entry_new_ts", m_timestamp, last_ts);
    end

    // Reset with one entry queued
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_reset_fill", fill, 3'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all_zero("midreset");

    // Enable gating: 5 disabled cycles delay the periodic tick from 8 to 13
    popped.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, (i == 2), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("gating_count", popped.size(), 2);
    if (popped.size() >= 2) begin
      chk("gating_trig_ts", popped[0].ts, 32'd6);
      chk("gating_trig_src", popped[0].src, 2'b10);
      chk("gating_periodic_ts", popped[1].ts, 32'd13);
      chk("gating_periodic_src", popped[1].src, 2'b01);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
